// File: rtl/float_result_buffer_if.sv
// Valid/ready handshake bundle between the float multiplier,
// the result buffer and the downstream consumer.
interface float_result_buffer_if #(
  parameter int FLOAT_SIZE = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLOAT_SIZE-1:0] in_result;
  logic                  in_overflow;
  logic                  in_underflow;
  logic                  in_inexact;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLOAT_SIZE-1:0] out_result;
  logic [2:0]            out_flags;

  modport slave (
    input  in_valid, in_result,
    input  in_overflow, in_underflow, in_inexact,
    output in_ready,
    output out_valid, out_result, out_flags,
    input  out_ready
  );

  modport master (
    output in_valid, in_result,
    output in_overflow, in_underflow, in_inexact,
    input  in_ready,
    input  out_valid, out_result, out_flags,
    output out_ready
  );
endinterface

// File: rtl/float_result_buffer.sv
// Elastic FIFO behind the float multiplier with
// software-clearable sticky exception flags.
module float_result_buffer #(
  parameter int FLOAT_SIZE = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  float_result_buffer_if.slave         bus,
  input  logic                         clear_sticky,
  output logic [2:0]                   sticky_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = FLOAT_SIZE + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sticky_q, sticky_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [2:0]    in_flags;
  logic [EW-1:0] head;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = bus.in_valid && !full;
  assign pop      = !empty && bus.out_ready;
  assign in_flags = {bus.in_overflow, bus.in_underflow,
                     bus.in_inexact};

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 1'b1;
      pop && !push: cnt_d = cnt_q - 1'b1;
      default:      cnt_d = cnt_q;
    endcase
    // a same-cycle push survives the clear
    if (clear_sticky) sticky_d = '0;
    if (push)         sticky_d = sticky_d | in_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.in_result, in_flags};
  end

  assign head           = mem_q[rd_q];
  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.out_result = empty ? '0 : head[EW-1:3];
  assign bus.out_flags  = empty ? '0 : head[2:0];
  assign sticky_flags   = sticky_q;
  assign count          = cnt_q;
endmodule

// File: tb/tb_float_result_buffer.sv
// Randomized and directed check of float_result_buffer
// against a queue-based reference model.
module tb_float_result_buffer;
  localparam int FS    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst_n;
  logic          clear_sticky;
  logic [2:0]    sticky_flags;
  logic [CW-1:0] count;

  float_result_buffer_if #(.FLOAT_SIZE(FS)) bif ();

  float_result_buffer #(.FLOAT_SIZE(FS), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif.slave),
    .clear_sticky(clear_sticky),
    .sticky_flags(sticky_flags),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [34:0] mq[$];
  logic [2:0]  msticky;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".in_ready"}, 64'(bif.in_ready), 64'(n < DEPTH));
    chk({tag, ".out_valid"}, 64'(bif.out_valid), 64'(n > 0));
    chk({tag, ".out_result"}, 64'(bif.out_result),
        n > 0 ? 64'(mq[0][34:3]) : 64'd0);
    chk({tag, ".out_flags"}, 64'(bif.out_flags),
        n > 0 ? 64'(mq[0][2:0]) : 64'd0);
    chk({tag, ".sticky"}, 64'(sticky_flags), 64'(msticky));
  endtask

  task automatic step(input string tag, input logic iv,
                      input logic [31:0] w, input logic [2:0] f,
                      input logic ordy, input logic clr);
    bit acc;
    bif.in_valid     = iv;
    bif.in_result    = w;
    bif.in_overflow  = f[2];
    bif.in_underflow = f[1];
    bif.in_inexact   = f[0];
    bif.out_ready    = ordy;
    clear_sticky     = clr;
    @(posedge clk);
    acc = iv && (mq.size() < DEPTH);
    if (ordy && mq.size() > 0) void'(mq.pop_front());
    if (clr) msticky = 3'b000;
    if (acc) begin
      mq.push_back({w, f});
      msticky = msticky | f;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    msticky = 3'b000;
    chk({tag, ".rst_in_ready"}, 64'(bif.in_ready), 64'd1);
    chk({tag, ".rst_out_valid"}, 64'(bif.out_valid), 64'd0);
    chk({tag, ".rst_count"}, 64'(count), 64'd0);
    chk({tag, ".rst_sticky"}, 64'(sticky_flags), 64'd0);
    chk({tag, ".rst_result"}, 64'(bif.out_result), 64'd0);
    chk({tag, ".rst_flags"}, 64'(bif.out_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] fill_w [4];
  logic [31:0] wv;

  initial begin
    rst_n = 1'b0;
    clear_sticky = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_result = '0;
    bif.in_overflow = 1'b0;
    bif.in_underflow = 1'b0;
    bif.in_inexact = 1'b0;
    bif.out_ready = 1'b0;
    msticky = 3'b000;
    fill_w[0] = 32'h3F800000;
    fill_w[1] = 32'h40000000;
    fill_w[2] = 32'h40400000;
    fill_w[3] = 32'h40800000;
    #12 rst_n = 1'b1;

    // leave something in flight, then reset mid-cycle
    step("pre", 1, 32'h1234, 3'b111, 0, 0);
    async_reset("r0");
    for (int i = 0; i < 10; i++) step("idle", 0, 32'hFFFF, 0, 0, 0);

    for (int i = 0; i < 4; i++) step("fill", 1, fill_w[i], 0, 0, 0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(bif.in_ready), 64'd0);
    step("drop", 1, 32'h40A00000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_word", 64'(bif.out_result), 64'(fill_w[i]));
      step("drain", 0, 0, 0, 1, 0);
    end
    chk("drain_count", 64'(count), 64'd0);

    wv = 32'd100;
    for (int i = 0; i < 2; i++) begin
      step("w_pre", 1, wv, 0, 0, 0);
      wv++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", 64'(bif.out_result), 64'(wv - 32'd2));
      step("wrap", 1, wv, 0, 1, 0);
      chk("wrap_count", 64'(count), 64'd2);
      wv++;
    end
    step("w_pop", 0, 0, 0, 1, 0);
    step("w_pop", 0, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) step("fp_fill", 1, 32'h500 + i, 0, 0, 0);
    step("fp_pop", 1, 32'h600, 0, 1, 0);
    chk("fp_count3", 64'(count), 64'd3);
    step("fp_push", 1, 32'h600, 0, 0, 0);
    chk("fp_count4", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step("fp_drain", 0, 0, 0, 1, 0);

    step("s_clr", 0, 0, 0, 0, 1);
    step("s_p1", 1, 32'h1, 3'b100, 0, 0);
    step("s_p2", 1, 32'h2, 3'b001, 0, 0);
    chk("sticky_101", 64'(sticky_flags), 64'b101);
    step("s_pop", 0, 0, 0, 1, 0);
    step("s_pop", 0, 0, 0, 1, 0);
    chk("sticky_keep", 64'(sticky_flags), 64'b101);
    step("s_clrpush", 1, 32'h3, 3'b010, 0, 1);
    chk("sticky_010", 64'(sticky_flags), 64'b010);
    step("s_clr2", 0, 0, 0, 0, 1);
    chk("sticky_000", 64'(sticky_flags), 64'b000);

    step("ig_idle", 0, 32'h9, 3'b100, 0, 0);
    chk("ig_sticky", 64'(sticky_flags), 64'b000);
    chk("ig_count", 64'(count), 64'd1);
    for (int i = 0; i < 3; i++) step("ig_fill", 1, 32'h700 + i, 0, 0, 0);
    step("ig_full", 1, 32'h777, 3'b001, 0, 0);
    chk("ig_full_sticky", 64'(sticky_flags), 64'b000);
    for (int i = 0; i < 4; i++) step("ig_drain", 0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("r1");
      step("rand", ($urandom % 4) != 0, $urandom,
           3'($urandom), ($urandom % 3) != 0,
           ($urandom % 16) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
